// File: rtl/pmic_pkg.sv
// pmic_pkg: types and constants shared by the PMIC sequencer and the LED top level.
//   state_t  - sequencer state encoding
//   MODE_*   - 3-bit mode/LED codes
//   mode_of  - maps a state to its mode code
package pmic_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_RAMP_UP,
        ST_ACTIVE,
        ST_LOW_POWER,
        ST_LOW_BATT,
        ST_RAMP_DOWN,
        ST_FAULT
    } state_t;

    localparam logic [2:0] MODE_OFF       = 3'b000;
    localparam logic [2:0] MODE_ACTIVE    = 3'b001;
    localparam logic [2:0] MODE_LOW_POWER = 3'b010;
    localparam logic [2:0] MODE_LOW_BATT  = 3'b100;
    localparam logic [2:0] MODE_FAULT     = 3'b111;

    function automatic logic [2:0] mode_of(input state_t s);
        case (s)
            ST_ACTIVE:    return MODE_ACTIVE;
            ST_LOW_POWER: return MODE_LOW_POWER;
            ST_LOW_BATT:  return MODE_LOW_BATT;
            ST_FAULT:     return MODE_FAULT;
            default:      return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/pmic_step_timer.sv
// pmic_step_timer: loadable down-counter used for rail step delays.
//   clk, reset - clock, asynchronous active-high reset (count -> 0)
//   ld         - load load_val this cycle (takes precedence over counting)
//   load_val   - reload value
//   zero       - count is 0; the counter holds at 0 until reloaded
module pmic_step_timer #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (ld) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pmic_seq.sv
// pmic_seq: power-rail sequencer. Enables N_RAILS rails in order on power-up and
// disables them in reverse order on power-down, one rail per STEP_CYCLES clocks.
// Up states ACTIVE / LOW_POWER / LOW_BATT apply rail masks directly.
//   clk, reset          - clock, asynchronous active-high reset
//   on_sw, lb_sw, lp_sw - asynchronous level requests (2-FF synchronised)
//   pg                  - per-rail power-good (synchronous)
//   rail_en             - registered rail enables
//   mode                - 001 ACTIVE, 010 LOW_POWER, 100 LOW_BATT, 111 FAULT, else 000
//   ready, fault        - up-state / fault indicators
// Build option: define PMIC_PG_CHECK_EN to enable power-good checking and FAULT;
// without it pg is ignored and fault is tied low.
module pmic_seq
    import pmic_pkg::*;
#(
    parameter int unsigned         N_RAILS     = 4,
    parameter int unsigned         STEP_CYCLES = 16,
    parameter logic [N_RAILS-1:0]  LP_MASK     = 'b0011,
    parameter logic [N_RAILS-1:0]  LB_MASK     = 'b0001,
    parameter int unsigned         PG_TIMEOUT  = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               on_sw,
    input  logic               lb_sw,
    input  logic               lp_sw,
    input  logic [N_RAILS-1:0] pg,
    output logic [N_RAILS-1:0] rail_en,
    output logic [2:0]         mode,
    output logic               ready,
    output logic               fault
);

    localparam int unsigned TMAX = (STEP_CYCLES > PG_TIMEOUT) ? STEP_CYCLES : PG_TIMEOUT;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned IW   = $clog2(N_RAILS);
    localparam logic [IW-1:0] LAST      = IW'(N_RAILS - 1);
    localparam logic [TW-1:0] STEP_LOAD = TW'(STEP_CYCLES - 1);

    state_t             state;
    logic [IW-1:0]      idx;
    logic [2:0]         sync1, sync2;
    logic               on_s, lb_s, lp_s;
    logic               tmr_ld, tmr_zero;
    logic               pg_ok;
    state_t             tgt_state;
    logic [N_RAILS-1:0] tgt_mask;
    logic [2:0]         tgt_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {on_sw, lb_sw, lp_sw};
            sync2 <= sync1;
        end
    end

    assign on_s = sync2[2];
    assign lb_s = sync2[1];
    assign lp_s = sync2[0];

`ifdef PMIC_PG_CHECK_EN
    localparam logic [TW-1:0] PG_LOAD = TW'(PG_TIMEOUT - 1);
    logic [TW-1:0] pg_cnt;
    logic          pg_zero;
    assign pg_ok   = pg[idx];
    assign pg_zero = (pg_cnt == '0);
`else
    logic unused_pg;
    assign unused_pg = ^pg;
    assign pg_ok     = 1'b1;
    assign fault     = 1'b0;
`endif

    // lb has priority over lp
    always_comb begin
        tgt_state = ST_ACTIVE;
        tgt_mask  = '1;
        if (lb_s) begin
            tgt_state = ST_LOW_BATT;
            tgt_mask  = LB_MASK;
        end else if (lp_s) begin
            tgt_state = ST_LOW_POWER;
            tgt_mask  = LP_MASK;
        end
        tgt_mode = mode_of(tgt_state);
    end

    // Reload the step timer on every rail enable/disable step.
    always_comb begin
        tmr_ld = 1'b0;
        case (state)
            ST_OFF:       tmr_ld = on_s;
            ST_RAMP_UP:   tmr_ld = !on_s || (tmr_zero && pg_ok && idx != LAST);
            ST_ACTIVE,
            ST_LOW_POWER,
            ST_LOW_BATT:  tmr_ld = !on_s;
            ST_RAMP_DOWN: tmr_ld = tmr_zero && idx != '0;
            default:      tmr_ld = 1'b0;
        endcase
    end

    pmic_step_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .ld       (tmr_ld),
        .load_val (STEP_LOAD),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_OFF;
            idx     <= '0;
            rail_en <= '0;
            mode    <= MODE_OFF;
            ready   <= 1'b0;
`ifdef PMIC_PG_CHECK_EN
            fault   <= 1'b0;
            pg_cnt  <= '0;
`endif
        end else begin
`ifdef PMIC_PG_CHECK_EN
            if (pg_cnt != '0) pg_cnt <= pg_cnt - 1'b1;
`endif
            case (state)
                ST_OFF: begin
                    if (on_s) begin
                        state   <= ST_RAMP_UP;
                        idx     <= '0;
                        rail_en <= {{(N_RAILS-1){1'b0}}, 1'b1};
`ifdef PMIC_PG_CHECK_EN
                        pg_cnt  <= PG_LOAD;
`endif
                    end
                end
                ST_RAMP_UP: begin
`ifdef PMIC_PG_CHECK_EN
                    if (!pg_ok && pg_zero) begin
                        state   <= ST_FAULT;
                        rail_en <= '0;
                        mode    <= MODE_FAULT;
                        fault   <= 1'b1;
                    end else
`endif
                    if (!on_s) begin
                        state        <= ST_RAMP_DOWN;
                        rail_en[idx] <= 1'b0;
                    end else if (tmr_zero && pg_ok) begin
                        if (idx == LAST) begin
                            state <= ST_ACTIVE;
                            mode  <= MODE_ACTIVE;
                            ready <= 1'b1;
                        end else begin
                            idx                 <= idx + 1'b1;
                            rail_en[idx + 1'b1] <= 1'b1;
`ifdef PMIC_PG_CHECK_EN
                            pg_cnt              <= PG_LOAD;
`endif
                        end
                    end
                end
                ST_ACTIVE, ST_LOW_POWER, ST_LOW_BATT: begin
`ifdef PMIC_PG_CHECK_EN
                    if ((rail_en & ~pg) != '0) begin
                        state   <= ST_FAULT;
                        rail_en <= '0;
                        mode    <= MODE_FAULT;
                        ready   <= 1'b0;
                        fault   <= 1'b1;
                    end else
`endif
                    if (!on_s) begin
                        state         <= ST_RAMP_DOWN;
                        idx           <= LAST;
                        rail_en[LAST] <= 1'b0;
                        mode          <= MODE_OFF;
                        ready         <= 1'b0;
                    end else begin
                        state   <= tgt_state;
                        rail_en <= tgt_mask;
                        mode    <= tgt_mode;
                    end
                end
                ST_RAMP_DOWN: begin
                    // Masked-off rails still take a full step.
                    if (tmr_zero) begin
                        if (idx == '0) begin
                            state <= ST_OFF;
                        end else begin
                            idx                 <= idx - 1'b1;
                            rail_en[idx - 1'b1] <= 1'b0;
                        end
                    end
                end
                ST_FAULT: begin
                    if (!on_s) begin
                        state <= ST_OFF;
                        mode  <= MODE_OFF;
`ifdef PMIC_PG_CHECK_EN
                        fault <= 1'b0;
`endif
                    end
                end
                default: state <= ST_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_pmic_seq.sv
// tb_pmic_seq: self-checking bench for pmic_seq (N_RAILS=4, STEP_CYCLES=8,
// LP_MASK=0011, LB_MASK=0001, PG_TIMEOUT=20). A timing-rule reference model tracks
// elapsed cycles per step and predicts rail_en/mode/ready every cycle, alongside
// directed checks of the headline scenarios and randomized input segments.
module tb_pmic_seq;

    localparam int N    = 4;
    localparam int STEP = 8;
    localparam int PGT  = 20;
    localparam logic [3:0] LPM = 4'b0011;
    localparam logic [3:0] LBM = 4'b0001;

    logic       clk = 1'b0;
    logic       reset;
    logic       on_sw, lb_sw, lp_sw;
    logic [3:0] pg;
    logic [3:0] rail_en;
    logic [2:0] mode;
    logic       ready, fault;

    always #5 clk = ~clk;

    pmic_seq #(
        .N_RAILS     (N),
        .STEP_CYCLES (STEP),
        .LP_MASK     (LPM),
        .LB_MASK     (LBM),
        .PG_TIMEOUT  (PGT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .on_sw   (on_sw),
        .lb_sw   (lb_sw),
        .lp_sw   (lp_sw),
        .pg      (pg),
        .rail_en (rail_en),
        .mode    (mode),
        .ready   (ready),
        .fault   (fault)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 off, 1 ramping up, 2 powered, 3 ramping down.
    // m_k = rail currently being stepped, m_t = cycles since that step began.
    int         m_ph, m_k, m_t;
    logic [3:0] m_rails;
    logic [2:0] m_mode;
    logic       m_ready;
    bit         q_on[$], q_lp[$], q_lb[$];

    function automatic void model_reset();
        m_ph = 0; m_k = 0; m_t = 0;
        m_rails = '0; m_mode = 3'b000; m_ready = 1'b0;
        q_on = '{0, 0}; q_lp = '{0, 0}; q_lb = '{0, 0};
    endfunction

    function automatic void model_step(input bit on, input bit lp, input bit lb);
        case (m_ph)
            0: if (on) begin
                m_ph = 1; m_k = 0; m_t = 0; m_rails = 4'b0001;
            end
            1: if (!on) begin
                m_ph = 3; m_rails[m_k] = 1'b0; m_t = 0;
            end else begin
                m_t++;
                if (m_t == STEP) begin
                    if (m_k == N - 1) begin
                        m_ph = 2; m_mode = 3'b001; m_ready = 1'b1;
                    end else begin
                        m_k++; m_rails[m_k] = 1'b1; m_t = 0;
                    end
                end
            end
            2: if (!on) begin
                m_ph = 3; m_k = N - 1; m_rails[m_k] = 1'b0; m_t = 0;
                m_mode = 3'b000; m_ready = 1'b0;
            end else if (lb) begin
                m_rails = LBM; m_mode = 3'b100;
            end else if (lp) begin
                m_rails = LPM; m_mode = 3'b010;
            end else begin
                m_rails = 4'hF; m_mode = 3'b001;
            end
            default: begin
                m_t++;
                if (m_t == STEP) begin
                    if (m_k == 0) m_ph = 0;
                    else begin
                        m_k--; m_rails[m_k] = 1'b0; m_t = 0;
                    end
                end
            end
        endcase
    endfunction

    function automatic logic [3:0] rpg();
`ifdef PMIC_PG_CHECK_EN
        return 4'hF;
`else
        return 4'($urandom);
`endif
    endfunction

    // One clock: drive at negedge, advance model at posedge, compare 1 time unit later.
    task automatic tick(input bit on, input bit lp, input bit lb, input logic [3:0] pgv, input bit chk);
        @(negedge clk);
        on_sw = on; lp_sw = lp; lb_sw = lb; pg = pgv;
        q_on.push_back(on); q_lp.push_back(lp); q_lb.push_back(lb);
        @(posedge clk);
        model_step(q_on.pop_front(), q_lp.pop_front(), q_lb.pop_front());
        #1;
        if (chk) begin
            check_eq("rail_en", rail_en, m_rails);
            check_eq("mode", mode, m_mode);
            check_eq("ready", ready, m_ready);
            check_eq("fault", fault, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; on_sw = 1'b0; lp_sw = 1'b0; lb_sw = 1'b0; pg = 4'hF;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        int  ready_cyc, full_cyc, found;
        bit  saw2;
        reset = 1'b1; on_sw = 1'b0; lp_sw = 1'b0; lb_sw = 1'b0; pg = 4'hF;
        model_reset();
        #12;
        check_eq("reset_rail_en", rail_en, 4'h0);
        check_eq("reset_mode", mode, 3'b000);
        check_eq("reset_ready", ready, 1'b0);
        check_eq("reset_fault", fault, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Power-up: rail 0 two edges after the sync, full at +24, ready 8 later.
        ready_cyc = -1; full_cyc = -1;
        for (int i = 0; i < 60; i++) begin
            tick(1, 0, 0, rpg(), 1);
            if (rail_en == 4'hF && full_cyc < 0) full_cyc = i;
            if (ready) begin ready_cyc = i; break; end
        end
        check_eq("t1_full_cycle", full_cyc, 26);
        check_eq("t1_ready_cycle", ready_cyc, 34);

        // Mode changes, 3 cycles after the switch each.
        repeat (3) tick(1, 1, 0, rpg(), 1);
        check_eq("t2_lp_rails", rail_en, 4'b0011);
        check_eq("t2_lp_mode", mode, 3'b010);
        repeat (3) tick(1, 1, 1, rpg(), 1);
        check_eq("t2_lb_rails", rail_en, 4'b0001);
        check_eq("t2_lb_mode", mode, 3'b100);
        repeat (3) tick(1, 0, 0, rpg(), 1);
        check_eq("t2_act_rails", rail_en, 4'hF);
        check_eq("t2_act_mode", mode, 3'b001);

        // Power-down: rail 3 off at tick 3, rail 0 off at tick 27, OFF at 35.
        repeat (3) tick(0, 0, 0, rpg(), 1);
        check_eq("t3_first_clear", rail_en, 4'b0111);
        repeat (24) tick(0, 0, 0, rpg(), 1);
        check_eq("t3_last_clear", rail_en, 4'b0000);
        repeat (10) tick(0, 0, 0, rpg(), 1);
        check_eq("t3_off_mode", mode, 3'b000);
        check_eq("t3_off_ready", ready, 1'b0);

        // Abort ramp-up at 0011: rail 2 must never assert.
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick(1, 0, 0, rpg(), 1);
            if (rail_en == 4'b0011) found = 1;
        end
        check_eq("t4_reach_0011", found, 1);
        saw2 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(0, 0, 0, rpg(), 1);
            if (rail_en[2]) saw2 = 1'b1;
        end
        check_eq("t4_rail2_never", saw2, 1'b0);
        check_eq("t4_end_rails", rail_en, 4'h0);

        // Asynchronous reset mid-ramp.
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            tick(1, 0, 0, rpg(), 1);
            if (rail_en == 4'b0111) found = 1;
        end
        check_eq("t5_reach_0111", found, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("t5_async_rails", rail_en, 4'h0);
        check_eq("t5_async_mode", mode, 3'b000);
        on_sw = 1'b0; lp_sw = 1'b0; lb_sw = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Randomized segments.
        for (int s = 0; s < 40; s++) begin
            bit on, lp, lb;
            int len;
            on  = ($urandom % 5) != 0;
            lp  = $urandom % 2;
            lb  = ($urandom % 3) == 0;
            len = $urandom_range(1, 30);
            for (int c = 0; c < len; c++) tick(on, lp, lb, rpg(), 1);
        end

`ifdef PMIC_PG_CHECK_EN
        begin
            int r1, f;
            do_reset();
            r1 = -1; f = -1;
            for (int i = 0; i < 80; i++) begin
                tick(1, 0, 0, 4'b1101, 0);
                if (rail_en[1] && r1 < 0) r1 = i;
                if (fault) begin f = i; break; end
            end
            check_eq("t6_fault_delay", f - r1, PGT);
            check_eq("t6_fault_rails", rail_en, 4'h0);
            check_eq("t6_fault_mode", mode, 3'b111);
            for (int i = 0; i < 10 && mode != 3'b000; i++) tick(0, 0, 0, 4'b1101, 0);
            check_eq("t6_exit_mode", mode, 3'b000);
            check_eq("t6_exit_fault", fault, 1'b0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
